// File: rtl/cla_addsub_seq.sv
// Sequential adder/subtractor: one 4-bit carry-lookahead slice reused once per nibble,
// LSB nibble first. Valid/ready handshake on the operand and result sides.
module cla_addsub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int MSB     = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic             sub_q;
  logic [CW-1:0]    cnt;
  logic [CW+1:0]    base;
  logic [4:0]       nib;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // 4-bit carry-lookahead slice: returns {c4, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

  always_comb begin
    base                = {cnt, 2'b00};
    nib                 = cla4(a_q[base +: 4], b_q[base +: 4], carry);
    res_next            = result;
    res_next[base +: 4] = nib[3:0];
    last                = (cnt == CW'(NIBBLES - 1));
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction folds into addition: a + ~b + ~borrow_in.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            sub_q <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= res_next;
          carry  <= nib[4];
          cnt    <= cnt + 1'b1;
          if (last) begin
            // Flags come from the completed result so they are ready with out_valid.
            cout  <= sub_q ? ~nib[4] : nib[4];
            ovf   <= (a_q[MSB] == b_q[MSB]) && (res_next[MSB] != a_q[MSB]);
            zero  <= (res_next == '0);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Bench for cla_addsub_seq: directed vector table, handshake/reset sequences and
// random operands checked against an integer-arithmetic reference model.
module tb_cla_addsub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;

  int tests = 0;
  int fails = 0;

  cla_addsub_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: signed/unsigned integer arithmetic on the full operands.
  task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                       input logic mcin, output logic [15:0] r, output logic c,
                       output logic o, output logic z);
    longint ua, ub, sa, sb, ufull, sfull;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      ufull = ua - ub - longint'(mcin);
      sfull = sa - sb - longint'(mcin);
      c     = (ufull < 0);
    end else begin
      ufull = ua + ub + longint'(mcin);
      sfull = sa + sb + longint'(mcin);
      c     = (ufull > 65535);
    end
    r = ufull[15:0];
    o = (sfull > 32767) || (sfull < -32768);
    z = (r == 16'h0000);
  endtask

  // Accept one operand set, wait for the result, complete the handshake.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                        input logic tc, output logic [15:0] r, output logic c,
                        output logic o, output logic z, output int lat);
    out_ready = 1'b1;
    a = ta; b = tb; sub = ts; cin = tc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; c = cout; o = ovf; z = zero;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] r, er;
    logic        c, o, z, ec, eo, ez;
    int          lat, pulses;
    logic [15:0] ra, rb;
    logic        rs, rc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #7;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset flags", {cout, ovf, zero}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, r, c, o, z, lat);
      check($sformatf("vec%0d latency", i), lat, 4);
      check($sformatf("vec%0d result", i), r, vecs[i].res);
      check($sformatf("vec%0d cout", i), c, vecs[i].cout);
      check($sformatf("vec%0d ovf", i), o, vecs[i].ovf);
      check($sformatf("vec%0d zero", i), z, vecs[i].zero);
      check($sformatf("vec%0d in_ready after", i), in_ready, 1);
    end

    // Backpressure: operand changes mid-RUN and in_valid pulses must be ignored.
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; in_valid = 1'b1;
      check("run in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold out_valid", out_valid, 1);
      check("hold result", result, 16'h3333);
      check("hold flags", {cout, ovf, zero}, 3'b000);
      check("hold in_ready", in_ready, 0);
      a = 16'h5555; b = 16'h0F0F; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after transfer out_valid", out_valid, 0);
    check("after transfer in_ready", in_ready, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) pulses++;
      @(posedge clk); #1;
    end
    check("no extra transfer", pulses, 0);

    // Reset two cycles after accept discards the operation.
    out_ready = 1'b1;
    a = 16'hAAAA; b = 16'h1111; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrun rst out_valid", out_valid, 0);
    check("midrun rst in_ready", in_ready, 1);
    check("midrun rst result", result, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulses = 0; r = '0; c = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        pulses++;
        r = result;
        c = cout;
      end
      @(posedge clk); #1;
    end
    check("post-reset pulses", pulses, 1);
    check("post-reset result", r, 16'h5555);
    check("post-reset cout", c, 0);

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      if (i < 10) rb = ~ra;
      model(ra, rb, rs, rc, er, ec, eo, ez);
      run_op(ra, rb, rs, rc, r, c, o, z, lat);
      check($sformatf("rand%0d latency", i), lat, 4);
      check($sformatf("rand%0d result a=%h b=%h s=%b c=%b", i, ra, rb, rs, rc), r, er);
      check($sformatf("rand%0d cout", i), c, ec);
      check($sformatf("rand%0d ovf", i), o, eo);
      check($sformatf("rand%0d zero", i), z, ez);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
